// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin arbiter sharing one combinational immediate
// extender between NUM_REQ requesters, with a single-entry response register.
module imm_ext_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  parameter  int unsigned TAG_W   = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*32-1:0]    i_req_instr,
  input  logic [NUM_REQ*3-1:0]     i_req_imm_src,
  input  logic [NUM_REQ*TAG_W-1:0] i_req_tag,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [31:0]              o_ext_instr,
  output logic [2:0]               o_ext_imm_src,
  input  logic [31:0]              i_ext_immediate,
  output logic                     o_rsp_valid,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [TAG_W-1:0]         o_rsp_tag,
  output logic [31:0]              o_rsp_immediate,
  output logic                     o_rsp_illegal,
  input  logic                     i_rsp_ready
);

  localparam int unsigned LAST_ID = NUM_REQ - 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   ptr_q;
  logic              slot_free;
  logic              gnt_any;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   cand;
  logic [NUM_REQ-1:0] gnt;
  logic [TAG_W-1:0]  gnt_tag;

  // Pick the first valid requester at or after the round-robin pointer.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    slot_free = (state_q == EMPTY) || i_rsp_ready;
    if (slot_free && !i_flush && i_rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = ID_W'((32'(ptr_q) + i) % NUM_REQ);
        if (!gnt_any && i_req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // One-hot grant and mux of the granted requester's fields onto the extender.
  always_comb begin
    gnt           = '0;
    o_ext_instr   = 32'h0;
    o_ext_imm_src = 3'b000;
    gnt_tag       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_any && (gnt_idx == ID_W'(k))) begin
        gnt[k]        = 1'b1;
        o_ext_instr   = i_req_instr[32*k +: 32];
        o_ext_imm_src = i_req_imm_src[3*k +: 3];
        gnt_tag       = i_req_tag[TAG_W*k +: TAG_W];
      end
    end
    o_req_ready = gnt;
  end

  // Response slot state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush empties, grant fills, drain without grant empties.
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else if (gnt_any) begin
      state_d = FULL;
    end else if ((state_q == FULL) && i_rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Output decode of the slot state.
  always_comb begin
    o_rsp_valid = (state_q == FULL);
  end

  // Round-robin pointer moves past the winner on each grant.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == ID_W'(LAST_ID)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Capture the extender result and request identity on the grant edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rsp_id        <= '0;
      o_rsp_tag       <= '0;
      o_rsp_immediate <= 32'h0;
      o_rsp_illegal   <= 1'b0;
    end else if (gnt_any) begin
      o_rsp_id        <= gnt_idx;
      o_rsp_tag       <= gnt_tag;
      o_rsp_immediate <= i_ext_immediate;
      o_rsp_illegal   <= (o_ext_imm_src > 3'd4);
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_imm_ext_arbiter;

  localparam int NR = 2;
  localparam int TW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [NR-1:0]    req_valid;
  logic [NR*32-1:0] req_instr;
  logic [NR*3-1:0]  req_src;
  logic [NR*TW-1:0] req_tag;
  logic [NR-1:0]    req_ready;
  logic [31:0]      ext_instr;
  logic [2:0]       ext_src;
  logic [31:0]      ext_imm;
  logic             rsp_valid;
  logic             rsp_id;
  logic [TW-1:0]    rsp_tag;
  logic [31:0]      rsp_imm;
  logic             rsp_illegal;
  logic             rsp_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state.
  bit          m_valid;
  int          m_ptr;
  int          m_id;
  logic [TW-1:0] m_tag;
  logic [31:0] m_imm;
  bit          m_ill;
  int          g_k;
  logic [NR-1:0] last_ready;

  imm_ext_arbiter #(.NUM_REQ(NR), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_req_valid(req_valid), .i_req_instr(req_instr),
    .i_req_imm_src(req_src), .i_req_tag(req_tag),
    .o_req_ready(req_ready), .o_ext_instr(ext_instr),
    .o_ext_imm_src(ext_src), .i_ext_immediate(ext_imm),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_tag(rsp_tag),
    .o_rsp_immediate(rsp_imm), .o_rsp_illegal(rsp_illegal),
    .i_rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  // RISC-V immediate formats; unsupported codes return the poison pattern.
  function automatic logic [31:0] imm_of(input logic [31:0] i, input logic [2:0] s);
    case (s)
      3'd0: imm_of = {{20{i[31]}}, i[31:20]};
      3'd1: imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: imm_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: imm_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4: imm_of = {i[31:12], 12'h000};
      default: imm_of = 32'hDEADBEEF;
    endcase
  endfunction

  // Stand-in for the shared combinational extender.
  always_comb ext_imm = imm_of(ext_instr, ext_src);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input bit v, input logic [31:0] ins,
                         input logic [2:0] s, input logic [TW-1:0] t);
    req_valid[k]          = v;
    req_instr[32*k +: 32] = ins;
    req_src[3*k +: 3]     = s;
    req_tag[TW*k +: TW]   = t;
  endtask

  // Check grant and extender drive against the model before the edge.
  task automatic check_comb();
    int k;
    logic [NR-1:0] er;
    logic [31:0]   ei;
    logic [2:0]    es;
    g_k = -1;
    if (rst_n && !flush && (!m_valid || rsp_ready)) begin
      for (int i = 0; i < NR; i++) begin
        k = (m_ptr + i) % NR;
        if (g_k < 0 && req_valid[k]) g_k = k;
      end
    end
    er = '0; ei = 32'h0; es = 3'b000;
    if (g_k >= 0) begin
      er[g_k] = 1'b1;
      ei = req_instr[32*g_k +: 32];
      es = req_src[3*g_k +: 3];
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("ext_instr", ext_instr, ei);
    chk("ext_imm_src", 32'(ext_src), 32'(es));
    last_ready = req_ready;
  endtask

  // Advance the model by one rising edge.
  task automatic model_edge();
    logic [31:0] ins;
    logic [2:0]  s;
    if (!rst_n) begin
      m_valid = 0; m_ptr = 0; m_id = 0; m_tag = '0; m_imm = 32'h0; m_ill = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (g_k >= 0) begin
      ins     = req_instr[32*g_k +: 32];
      s       = req_src[3*g_k +: 3];
      m_valid = 1;
      m_id    = g_k;
      m_tag   = req_tag[TW*g_k +: TW];
      m_imm   = imm_of(ins, s);
      m_ill   = (s > 3'd4);
      m_ptr   = (g_k + 1) % NR;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_regs();
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_tag", 32'(rsp_tag), 32'(m_tag));
    chk("rsp_immediate", rsp_imm, m_imm);
    chk("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
  endtask

  // One clock: inputs already driven in the low phase.
  task automatic cycle();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle_inputs();
    flush = 0; req_valid = '0; req_instr = '0; req_src = '0; req_tag = '0;
  endtask

  initial begin
    m_valid = 0; m_ptr = 0; m_id = 0; m_tag = '0; m_imm = 32'h0; m_ill = 0;
    rst_n = 0; rsp_ready = 1; idle_inputs();
    cycle(); cycle();
    chk("reset_valid", 32'(rsp_valid), 32'h0);
    chk("reset_imm", rsp_imm, 32'h0);
    rst_n = 1;

    // Single I-type request.
    set_req(0, 1, 32'hFFF00093, 3'd0, 4'h3); cycle();
    chk("t1_valid", 32'(rsp_valid), 32'h1);
    chk("t1_imm", rsp_imm, 32'hFFFFFFFF);
    chk("t1_id", 32'(rsp_id), 32'h0);
    chk("t1_illegal", 32'(rsp_illegal), 32'h0);

    // U-type from req1 then S-type from req0.
    idle_inputs(); set_req(1, 1, 32'h12345037, 3'd4, 4'hA); cycle();
    chk("t2_imm_u", rsp_imm, 32'h12345000);
    chk("t2_id_u", 32'(rsp_id), 32'h1);
    chk("t2_tag_u", 32'(rsp_tag), 32'hA);
    idle_inputs(); set_req(0, 1, 32'hFE112E23, 3'd1, 4'h5); cycle();
    chk("t2_imm_s", rsp_imm, 32'hFFFFFFFC);

    // Park the pointer at req0, then alternate with both requesting.
    idle_inputs(); set_req(1, 1, 32'h00100093, 3'd0, 4'h1); cycle();
    set_req(0, 1, 32'h00200093, 3'd0, 4'h2);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_grant", 32'(last_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("t3_no_bubble", 32'(rsp_valid), 32'h1);
      chk("t3_id", 32'(rsp_id), 32'(i % 2));
    end

    // Backpressure hold, then drain and load together.
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_hold_ready", 32'(last_ready), 32'h0);
      chk("t4_hold_id", 32'(rsp_id), 32'h1);
    end
    rsp_ready = 1; cycle();
    chk("t4_drain_load_grant", 32'(last_ready), 32'h1);
    chk("t4_drain_load_valid", 32'(rsp_valid), 32'h1);
    chk("t4_drain_load_id", 32'(rsp_id), 32'h0);

    // Illegal format, then flush of a held response.
    idle_inputs(); set_req(0, 1, 32'h0000A0B7, 3'd7, 4'h7); cycle();
    chk("t5_imm", rsp_imm, 32'hDEADBEEF);
    chk("t5_illegal", 32'(rsp_illegal), 32'h1);
    rsp_ready = 0; flush = 1; set_req(1, 1, 32'h0, 3'd0, 4'h0); cycle();
    chk("t5_flush_grant", 32'(last_ready), 32'h0);
    chk("t5_flush_valid", 32'(rsp_valid), 32'h0);

    // Reset while full, pointer returns to req0.
    idle_inputs(); set_req(0, 1, 32'hFFF00093, 3'd0, 4'h9); cycle();
    rst_n = 0; set_req(1, 1, 32'h12345037, 3'd4, 4'hB); cycle();
    chk("t6_rst_ready", 32'(last_ready), 32'h0);
    chk("t6_rst_valid", 32'(rsp_valid), 32'h0);
    chk("t6_rst_tag", 32'(rsp_tag), 32'h0);
    chk("t6_rst_imm", rsp_imm, 32'h0);
    rst_n = 1; rsp_ready = 1; cycle();
    chk("t6_first_grant", 32'(last_ready), 32'h1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(63) != 0);
      flush     = ($urandom_range(15) == 0);
      rsp_ready = ($urandom_range(3) != 0);
      for (int k = 0; k < NR; k++)
        set_req(k, ($urandom_range(2) != 0), $urandom, 3'($urandom_range(7)),
                TW'($urandom_range(15)));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
